vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

- Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock: hSync, vSync, bright, hCount and vCount.
- Sits upstream of the game renderer, which maps (hCount, vCount) to rgb and qualifies its output with bright.
- Visible area is hCount 144..783, vCount 35..514.
- Also issues a per-frame tick and, optionally, a divided slow game clock for object motion.

## Interface
- CLK_DIV, 4: clk cycles per pixel; 100 MHz / 4 = 25 MHz pixel rate. Legal values are 2..16.
- H_TOTAL, 800: pixels per line (hCount 0..H_TOTAL-1).
- H_SYNC, 96: hSync is low for hCount 0..H_SYNC-1.
- H_ACT_START, 144 / H_ACT_END, 784: bright horizontal window, [start, end).
- V_TOTAL, 525: lines per frame (vCount 0..V_TOTAL-1).
- V_SYNC, 2: vSync is low for vCount 0..V_SYNC-1.
- V_ACT_START, 35 / V_ACT_END, 515: bright vertical window, [start, end).
- GAME_DIV, 2: frames per game_clk half-period. Only used with GAME_CLK_EN.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- pix_en  out  1  one-clk strobe, once every CLK_DIV cycles.
- hCount  out  10  horizontal pixel counter.
- vCount  out  10  vertical line counter.
- hSync  out  1  horizontal sync, active-low.
- vSync  out  1  vertical sync, active-low.
- bright  out  1  high inside the visible window.
- frame_tick  out  1  one-clk strobe on the last pixel of the frame.
- game_clk  out  1  slow square wave for game logic.

## Operation
- The divider div_cnt counts 0..CLK_DIV-1 on every clk edge and then wraps to 0.
- pix_en = (div_cnt == CLK_DIV-1), decoded combinationally from the register.
- On a clk edge where pix_en=1:
  - hCount increments. At H_TOTAL-1 it wraps to 0.
  - On that same wrap edge, vCount increments. At V_TOTAL-1 it wraps to 0.
  - hCount and vCount never hold values ≥ H_TOTAL or ≥ V_TOTAL.
- hSync = ~(hCount < H_SYNC).
- vSync = ~(vCount < V_SYNC).
- bright = (H_ACT_START ≤ hCount < H_ACT_END) && (V_ACT_START ≤ vCount < V_ACT_END).
- hSync, vSync and bright are combinational decodes of the counter registers. They change in the same cycle as the counters, with no skew between count and flags.
- frame_tick = pix_en && hCount==H_TOTAL-1 && vCount==V_TOTAL-1. It is high for exactly one clk per frame.
- Reset values:
  - div_cnt, hCount, vCount all 0.
  - hSync=0 and vSync=0, since count 0 lies in the sync pulse.
  - bright=0, pix_en=0, frame_tick=0, game_clk=0.
- Reset asserted mid-frame returns every counter to 0 immediately (asynchronously). The raster restarts cleanly at frame start after reset deasserts.
- Counter arithmetic is unsigned 10-bit. All comparisons are unsigned.

## Timing
- After rst deasserts, the first pix_en is on the CLK_DIV-th clk edge, i.e. the 4th edge.
- hCount first reads 1 after that edge.
- Line period = H_TOTAL × CLK_DIV = 3200 clk.
- Frame period = 525 × 3200 = 1,680,000 clk, which is 16.8 ms at 100 MHz.
- hSync low width = 96 × 4 = 384 clk.
- vSync low width = 2 lines = 6400 clk.
- frame_tick rises on the clk where vCount=524 and hCount=799 with pix_en high. On the next edge both counters read 0.

## Configuration
- Macro GAME_CLK_EN.
- Defined:
  - A frame counter counts frame_tick events from 0 to GAME_DIV-1.
  - On the frame_tick that completes the count, the frame counter wraps and game_clk toggles.
  - Period of game_clk = 2 × GAME_DIV frames (30 Hz at GAME_DIV=1, 15 Hz at 2).
  - Reset clears both the frame counter and game_clk.
- Undefined: game_clk is tied 0, and no frame-counter logic is generated.

## Test plan
- Reset release: after rst 1→0, hCount/vCount hold 0 for the first 3 edges. At edge 4, pix_en=1 and hCount becomes 1. hSync and vSync are 0 throughout.
- Horizontal sweep:
  - hSync rises when hCount goes 95→96.
  - bright rises when hCount goes 143→144, with vCount=35.
  - bright falls when hCount goes 783→784.
  - hCount wraps 799→0 and vCount increments in the same edge.
- Vertical sweep over a full frame:
  - vSync is low only for vCount 0–1.
  - bright is never high for vCount <35 or ≥515.
  - vCount wraps 524→0.
  - Exactly one frame_tick per 1,680,000 clk.
- Mid-frame reset: assert rst at hCount=400, vCount=300 → all counters and outputs return to their reset values without waiting for a clk edge. The raster then restarts from (0,0).
- GAME_CLK_EN with GAME_DIV=2: game_clk toggles on every 2nd frame_tick and reads 0,1,0 at frame_tick counts 0,2,4. Without the macro, game_clk stays 0 for 5 frames.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing from the 100 MHz system clock.
// Produces a pixel-rate strobe, free-running hCount/vCount, active-low syncs,
// the visible-window qualifier and a once-per-frame tick.
// Optional feature macro GAME_CLK_EN adds a frame-divided square wave on game_clk;
// without it game_clk is tied low and no frame counter is built.

module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515,
  parameter int GAME_DIV    = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick,
  output logic       game_clk
);

  localparam logic [3:0] DIV_LAST    = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_FIRST = 10'(H_ACT_START);
  localparam logic [9:0] H_ACT_STOP  = 10'(H_ACT_END);
  localparam logic [9:0] V_ACT_FIRST = 10'(V_ACT_START);
  localparam logic [9:0] V_ACT_STOP  = 10'(V_ACT_END);

  // Counters are 10 bits and the divider 4 bits, so oversized settings cannot work.
  if (CLK_DIV < 2 || CLK_DIV > 16 || H_TOTAL > 1024 || V_TOTAL > 1024 || GAME_DIV < 1)
  begin : g_badParams
    $error("vga_timing_gen: unsupported CLK_DIV, H_TOTAL, V_TOTAL or GAME_DIV");
  end

  logic [3:0] r_divCnt;
  logic [9:0] r_hCount;
  logic [9:0] r_vCount;
  logic       w_pixEn;
  logic       w_hLast;
  logic       w_vLast;
  logic       w_frameTick;

  assign w_pixEn     = (r_divCnt == DIV_LAST);
  assign w_hLast     = (r_hCount == H_LAST);
  assign w_vLast     = (r_vCount == V_LAST);
  assign w_frameTick = w_pixEn && w_hLast && w_vLast;

  // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps on the strobe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divCnt <= '0;
    end else if (w_pixEn) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + 4'd1;
    end
  end

  // Raster counters: hCount advances per pixel, vCount advances on the line wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hCount <= '0;
      r_vCount <= '0;
    end else if (w_pixEn) begin
      if (w_hLast) begin
        r_hCount <= '0;
        if (w_vLast) begin
          r_vCount <= '0;
        end else begin
          r_vCount <= r_vCount + 10'd1;
        end
      end else begin
        r_hCount <= r_hCount + 10'd1;
      end
    end
  end

  // Flags decode straight from the count registers so they never skew against them.
  always_comb begin
    pix_en     = w_pixEn;
    hCount     = r_hCount;
    vCount     = r_vCount;
    hSync      = !(r_hCount < H_SYNC_END);
    vSync      = !(r_vCount < V_SYNC_END);
    bright     = (r_hCount >= H_ACT_FIRST) && (r_hCount < H_ACT_STOP) &&
                 (r_vCount >= V_ACT_FIRST) && (r_vCount < V_ACT_STOP);
    frame_tick = w_frameTick;
  end

`ifdef GAME_CLK_EN
  localparam int             FRAME_W    = (GAME_DIV > 1) ? $clog2(GAME_DIV) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(GAME_DIV - 1);

  logic [FRAME_W-1:0] r_frameCnt;
  logic               r_gameClk;

  // Frame divider: every GAME_DIV frame ticks the game clock flips phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frameCnt <= '0;
      r_gameClk  <= 1'b0;
    end else if (w_frameTick) begin
      if (r_frameCnt == FRAME_LAST) begin
        r_frameCnt <= '0;
        r_gameClk  <= ~r_gameClk;
      end else begin
        r_frameCnt <= r_frameCnt + 1'b1;
      end
    end
  end

  assign game_clk = r_gameClk;
`else
  assign game_clk = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Three instances share one clock: A uses the full 640x480 timing for reset release
// and the first lines, B keeps the real vertical timing with a short line so a whole
// frame fits, C is a tiny raster used to watch frame ticks and game_clk over 5 frames.
// Stimulus pushes hand-computed expectations keyed by pixel-strobe index; per-instance
// monitors pop and compare whenever pix_en (or frame_tick) is presented.

module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA = 1'b1;
  logic rstB = 1'b1;
  logic rstC = 1'b1;

  logic       pixEnA, hsA, vsA, brA, ftA, gcA;
  logic       pixEnB, hsB, vsB, brB, ftB, gcB;
  logic       pixEnC, hsC, vsC, brC, ftC, gcC;
  logic [9:0] hA, vA, hB, vB, hC, vC;

  vga_timing_gen dutA (
    .clk(clk), .rst(rstA), .pix_en(pixEnA), .hCount(hA), .vCount(vA),
    .hSync(hsA), .vSync(vsA), .bright(brA), .frame_tick(ftA), .game_clk(gcA)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(17),
    .V_TOTAL(525), .V_SYNC(2), .V_ACT_START(35), .V_ACT_END(515), .GAME_DIV(2)
  ) dutB (
    .clk(clk), .rst(rstB), .pix_en(pixEnB), .hCount(hB), .vCount(vB),
    .hSync(hsB), .vSync(vsB), .bright(brB), .frame_tick(ftB), .game_clk(gcB)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(17),
    .V_TOTAL(12), .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(10), .GAME_DIV(2)
  ) dutC (
    .clk(clk), .rst(rstC), .pix_en(pixEnC), .hCount(hC), .vCount(vC),
    .hSync(hsC), .vSync(vsC), .bright(brC), .frame_tick(ftC), .game_clk(gcC)
  );

  typedef struct {
    int idx;
    int h;
    int v;
    bit hs;
    bit vs;
    bit br;
    bit ft;
  } vec_t;

  typedef struct {
    int edgeNum;
    bit gc;
  } tick_t;

  vec_t  qA[$];
  vec_t  qB[$];
  tick_t qC[$];

  int nVectors   = 0;
  int nMiss      = 0;
  int pixCntA    = 0;
  int pixCntB    = 0;
  int edgesB     = 0;
  int edgesC     = 0;
  int ticksB     = 0;
  int ftEdgeB    = -1;
  int invErrB    = 0;
  int extraTickC = 0;

  function automatic vec_t mkVec(input int idx, input int h, input int v,
                                 input bit hs, input bit vs, input bit br, input bit ft);
    vec_t r;
    r.idx = idx; r.h = h; r.v = v; r.hs = hs; r.vs = vs; r.br = br; r.ft = ft;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVectors++;
    if (actual !== expected) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkVec(input string tag, input vec_t e,
                          input logic [9:0] h, input logic [9:0] v,
                          input logic hs, input logic vs, input logic br, input logic ft);
    logic [23:0] act;
    logic [23:0] exp;
    act = {h, v, hs, vs, br, ft};
    exp = {10'(e.h), 10'(e.v), e.hs, e.vs, e.br, e.ft};
    nVectors++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s[pix %0d]: got h=%0d v=%0d hs=%b vs=%b br=%b ft=%b, expected h=%0d v=%0d hs=%b vs=%b br=%b ft=%b",
               tag, e.idx, h, v, hs, vs, br, ft, e.h, e.v, e.hs, e.vs, e.br, e.ft);
    end
  endtask

  // Edge counters since reset release, used to time frame ticks.
  always @(posedge clk) begin
    edgesB <= rstB ? 0 : edgesB + 1;
    edgesC <= rstC ? 0 : edgesC + 1;
  end

  // Monitor A: compare queued vectors at their pixel-strobe index.
  always @(negedge clk) begin
    if (rstA) begin
      pixCntA <= 0;
    end else if (pixEnA) begin
      if (qA.size() > 0 && qA[0].idx == pixCntA)
        checkVec("A", qA.pop_front(), hA, vA, hsA, vsA, brA, ftA);
      pixCntA <= pixCntA + 1;
    end
  end

  // Monitor B: queued vectors plus whole-frame window/sync/tick properties.
  always @(negedge clk) begin
    if (rstB) begin
      pixCntB <= 0;
      ticksB  <= 0;
      ftEdgeB <= -1;
    end else begin
      if (pixEnB) begin
        if (qB.size() > 0 && qB[0].idx == pixCntB)
          checkVec("B", qB.pop_front(), hB, vB, hsB, vsB, brB, ftB);
        pixCntB <= pixCntB + 1;
        if ((brB && (vB < 35 || vB >= 515)) || (vsB !== (vB >= 2)) ||
            (hB >= 20) || (vB >= 525))
          invErrB <= invErrB + 1;
      end
      if (ftB) begin
        ticksB  <= ticksB + 1;
        ftEdgeB <= edgesB;
        if (!pixEnB) invErrB <= invErrB + 1;
      end
    end
  end

  // Monitor C: on every frame tick check its timing and the game clock phase.
  always @(negedge clk) begin
    if (!rstC && ftC) begin
      if (qC.size() > 0) begin
        tick_t e;
        e = qC.pop_front();
        checkOutput("C_tickEdge", edgesC, e.edgeNum);
        checkOutput("C_gameClk", int'(gcC), int'(e.gc));
      end else begin
        extraTickC <= extraTickC + 1;
      end
    end
  end

  // Full-size raster: reset values, release timing, first lines.
  task automatic applyStimulusA;
    rstA = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("A_rst_h", int'(hA), 0);
    checkOutput("A_rst_v", int'(vA), 0);
    checkOutput("A_rst_hSync", int'(hsA), 0);
    checkOutput("A_rst_vSync", int'(vsA), 0);
    checkOutput("A_rst_bright", int'(brA), 0);
    checkOutput("A_rst_pixEn", int'(pixEnA), 0);
    checkOutput("A_rst_ft", int'(ftA), 0);
    checkOutput("A_rst_gameClk", int'(gcA), 0);
    qA.push_back(mkVec(95,   95,  0, 0, 0, 0, 0));
    qA.push_back(mkVec(96,   96,  0, 1, 0, 0, 0));
    qA.push_back(mkVec(143,  143, 0, 1, 0, 0, 0));
    qA.push_back(mkVec(144,  144, 0, 1, 0, 0, 0));
    qA.push_back(mkVec(783,  783, 0, 1, 0, 0, 0));
    qA.push_back(mkVec(799,  799, 0, 1, 0, 0, 0));
    qA.push_back(mkVec(800,  0,   1, 0, 0, 0, 0));
    qA.push_back(mkVec(1599, 799, 1, 1, 0, 0, 0));
    qA.push_back(mkVec(1600, 0,   2, 0, 1, 0, 0));
    @(posedge clk);
    #2 rstA = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("A_rel_edge%0d_h", e), int'(hA), (e == 4) ? 1 : 0);
      checkOutput($sformatf("A_rel_edge%0d_pixEn", e), int'(pixEnA), (e == 3) ? 1 : 0);
      checkOutput($sformatf("A_rel_edge%0d_syncs", e), int'({hsA, vsA}), 0);
    end
    for (int i = 0; i < 7000 && qA.size() > 0; i++) @(posedge clk);
    checkOutput("A_pending", qA.size(), 0);
    rstA = 1'b1;
  endtask

  // Real vertical timing: mid-frame async reset, then one complete frame.
  task automatic applyStimulusB;
    bit found;
    found = 1'b0;
    @(posedge clk);
    #2 rstB = 1'b0;
    for (int i = 0; i < 13000 && !found; i++) begin
      @(negedge clk);
      if (hB == 10'd10 && vB == 10'd300) found = 1'b1;
    end
    checkOutput("B_reach_10_300", int'(found), 1);
    checkOutput("B_mid_flags", int'({hsB, vsB, brB}), 7);
    #2 rstB = 1'b1;
    #1;
    checkOutput("B_async_h", int'(hB), 0);
    checkOutput("B_async_v", int'(vB), 0);
    checkOutput("B_async_flags", int'({hsB, vsB, brB, pixEnB, ftB}), 0);
    qB.push_back(mkVec(0,     0,  0,   0, 0, 0, 0));
    qB.push_back(mkVec(3,     3,  0,   1, 0, 0, 0));
    qB.push_back(mkVec(40,    0,  2,   0, 1, 0, 0));
    qB.push_back(mkVec(699,   19, 34,  1, 1, 0, 0));
    qB.push_back(mkVec(700,   0,  35,  0, 1, 0, 0));
    qB.push_back(mkVec(704,   4,  35,  1, 1, 0, 0));
    qB.push_back(mkVec(705,   5,  35,  1, 1, 1, 0));
    qB.push_back(mkVec(716,   16, 35,  1, 1, 1, 0));
    qB.push_back(mkVec(717,   17, 35,  1, 1, 0, 0));
    qB.push_back(mkVec(10296, 16, 514, 1, 1, 1, 0));
    qB.push_back(mkVec(10305, 5,  515, 1, 1, 0, 0));
    qB.push_back(mkVec(10499, 19, 524, 1, 1, 0, 1));
    qB.push_back(mkVec(10500, 0,  0,   0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #2 rstB = 1'b0;
    for (int i = 0; i < 22000 && qB.size() > 0; i++) @(posedge clk);
    checkOutput("B_pending", qB.size(), 0);
    checkOutput("B_ticks", ticksB, 1);
    checkOutput("B_tickEdge", ftEdgeB, 20999);
    checkOutput("B_invariants", invErrB, 0);
    rstB = 1'b1;
  endtask

  // Tiny raster: five frame ticks and the game clock phase at each.
  task automatic applyStimulusC;
    bit gcTab [5];
`ifdef GAME_CLK_EN
    gcTab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    gcTab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    #1;
    checkOutput("C_rst_gameClk", int'(gcC), 0);
    for (int k = 0; k < 5; k++) begin
      tick_t t;
      t.edgeNum = 480 * (k + 1) - 1;
      t.gc      = gcTab[k];
      qC.push_back(t);
    end
    @(posedge clk);
    #2 rstC = 1'b0;
    for (int i = 0; i < 3000 && qC.size() > 0; i++) @(posedge clk);
    checkOutput("C_pending", qC.size(), 0);
    checkOutput("C_extraTicks", extraTickC, 0);
    rstC = 1'b1;
  endtask

  initial begin
    $display("[TB] vga_timing_gen bench start");
    applyStimulusA;
    applyStimulusB;
    applyStimulusC;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
